// File: rtl/seven_seg_rx.sv
// Snoops a two-digit multiplexed seven-segment display and recovers the shown byte,
// decimal points, illegal-pattern events and a staleness flag.
module seven_seg_rx #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cc_in,
  input  logic [6:0] an_in,
  input  logic       dp_in,
  output logic [7:0] d_out,
  output logic [1:0] dp_out,
  output logic       frame_valid,
  output logic       changed,
  output logic       seg_err,
  output logic [7:0] err_cnt,
  output logic       stale
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {SEL_NONE, SEL_HI, SEL_LO} sel_t;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  logic [1:0]      cc_s1, cc_s2;
  logic [6:0]      an_s1, an_s2;
  logic            dp_s1, dp_s2;
  sel_t            sel, sel_q;
  logic [6:0]      an_q;
  logic            dp_q;
  logic            diff_in;
  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            accept;
  logic            legal;
  logic [3:0]      nib;
  logic [3:0]      stg_hi, stg_lo;
  logic            dp_hi, dp_lo;
  logic            got_hi, got_lo;
  logic            assemble;
  logic [TO_W-1:0] to_cnt, to_nxt;

  // Two-flop synchronizers plus the previous-sample copy used for change detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_s1 <= '0; cc_s2 <= '0;
      an_s1 <= '0; an_s2 <= '0;
      dp_s1 <= 1'b0; dp_s2 <= 1'b0;
      sel_q <= SEL_NONE; an_q <= '0; dp_q <= 1'b0;
    end else begin
      cc_s1 <= cc_in; cc_s2 <= cc_s1;
      an_s1 <= an_in; an_s2 <= an_s1;
      dp_s1 <= dp_in; dp_s2 <= dp_s1;
      sel_q <= sel;   an_q  <= an_s2; dp_q <= dp_s2;
    end
  end

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    sel = SEL_NONE;
    unique case (cc_s2)
      2'b01:   sel = SEL_HI;
      2'b10:   sel = SEL_LO;
      default: sel = SEL_NONE;
    endcase
  end

  assign diff_in = (sel != sel_q) || (an_s2 != an_q) || (dp_s2 != dp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The change cycle counts as the first stable sample; the SETTLE-th one accepts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (diff_in) begin
      state_nxt = (sel == SEL_NONE) ? S_IDLE : S_SETTLE;
      cnt_nxt   = (sel == SEL_NONE) ? '0 : CNT_W'(1);
    end else if (state == S_SETTLE) begin
      if (cnt == CNT_W'(SETTLE - 1)) begin
        accept    = 1'b1;
        state_nxt = S_HELD;
        cnt_nxt   = CNT_W'(SETTLE);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (an_s2)
      7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
      7'h58: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  assign assemble = got_hi & got_lo;

  // Only a legal accept proves the display is alive; illegal ones let the count run on.
  always_comb begin
    if (accept && legal)                to_nxt = '0;
    else if (to_cnt == TO_W'(TIMEOUT))  to_nxt = to_cnt;
    else                                to_nxt = to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_hi <= '0; stg_lo <= '0;
      dp_hi  <= 1'b0; dp_lo <= 1'b0;
      got_hi <= 1'b0; got_lo <= 1'b0;
      d_out  <= '0; dp_out <= '0;
      frame_valid <= 1'b0; changed <= 1'b0;
      seg_err <= 1'b0; err_cnt <= '0;
      to_cnt <= '0; stale <= 1'b0;
    end else begin
      frame_valid <= assemble;
      changed     <= assemble && ({stg_hi, stg_lo, dp_hi, dp_lo} != {d_out, dp_out});
      seg_err     <= accept && !legal;
      to_cnt      <= to_nxt;
      // stale survives a lone accept and clears only when a whole frame lands.
      stale       <= !assemble && (stale || (to_nxt == TO_W'(TIMEOUT)));
      if (accept && !legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (accept && legal) begin
        if (sel == SEL_HI) begin
          stg_hi <= nib; dp_hi <= dp_s2; got_hi <= 1'b1;
        end else begin
          stg_lo <= nib; dp_lo <= dp_s2; got_lo <= 1'b1;
        end
      end
      if (assemble) begin
        d_out  <= {stg_hi, stg_lo};
        dp_out <= {dp_hi, dp_lo};
        got_hi <= 1'b0;
        got_lo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed and randomized bench for seven_seg_rx, checked against a run-length
// model of the display (a dwell is accepted once it has lasted SETTLE cycles).
module tb_seven_seg_rx;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cc_in;
  logic [6:0] an_in;
  logic       dp_in;
  logic [7:0] d_out;
  logic [1:0] dp_out;
  logic       frame_valid, changed, seg_err, stale;
  logic [7:0] err_cnt;

  seven_seg_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cc_in(cc_in), .an_in(an_in), .dp_in(dp_in),
    .d_out(d_out), .dp_out(dp_out), .frame_valid(frame_valid), .changed(changed),
    .seg_err(seg_err), .err_cnt(err_cnt), .stale(stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: frames as {changed, dp_out, d_out}, seg_err pulses, stale rise time.
  int          cyc = 0;
  logic [10:0] got_q[$];
  int          seg_pulses = 0;
  int          last_fv_cyc = -1;
  int          stale_rise_cyc = -1;
  logic        stale_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_valid === 1'b1) begin
      got_q.push_back({changed, dp_out, d_out});
      last_fv_cyc = cyc;
    end
    if (seg_err === 1'b1) seg_pulses++;
    if (stale === 1'b1 && stale_d !== 1'b1) stale_rise_cyc = cyc;
    stale_d = stale;
  end

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  function automatic int seg_val(input logic [6:0] an);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == an) return i;
    return -1;
  endfunction

  function automatic int sel_of(input logic [1:0] cc);
    return (cc == 2'b01) ? 1 : (cc == 2'b10) ? 2 : 0;
  endfunction

  // Reference model state.
  int          m_hi, m_lo, m_err, m_seg = 0;
  bit          m_dph, m_dpl, m_gh, m_gl;
  logic [9:0]  m_last;
  logic [10:0] exp_q[$];
  logic [9:0]  run_key;
  int          run_len;
  bit          run_acc;

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_dph = 0; m_dpl = 0; m_gh = 0; m_gl = 0;
    m_last = '0; m_err = 0;
    run_key = '0; run_len = 1; run_acc = 1;
  endtask

  task automatic model_dwell(input logic [1:0] cc, input logic [6:0] an, input bit dp, input int n);
    int s, v;
    logic [9:0] key, frame;
    s   = sel_of(cc);
    key = {2'(s), an, dp};
    if (key == run_key) run_len += n;
    else begin
      run_key = key; run_len = n; run_acc = 0;
    end
    if (!run_acc && s != 0 && run_len >= SETTLE) begin
      run_acc = 1;
      v = seg_val(an);
      if (v < 0) begin
        m_seg++;
        if (m_err < 255) m_err++;
      end else begin
        if (s == 1) begin m_hi = v; m_dph = dp; m_gh = 1; end
        else        begin m_lo = v; m_dpl = dp; m_gl = 1; end
        if (m_gh && m_gl) begin
          frame = {m_dph, m_dpl, 4'(m_hi), 4'(m_lo)};
          exp_q.push_back({frame != m_last, frame});
          m_last = frame;
          m_gh = 0; m_gl = 0;
        end
      end
    end
  endtask

  // Drives one dwell; fv_at is the dwell cycle (1-based) of the first frame_valid, 0 if none.
  task automatic drive(input logic [1:0] cc, input logic [6:0] an, input bit dp, input int n,
                       output int fv_at);
    cc_in = cc; an_in = an; dp_in = dp;
    model_dwell(cc, an, dp, n);
    fv_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1 && fv_at == 0) fv_at = k;
    end
  endtask

  task automatic dw(input logic [1:0] cc, input logic [6:0] an, input bit dp, input int n);
    int unused_fv;
    drive(cc, an, dp, n, unused_fv);
  endtask

  task automatic compare_frames(input string tag);
    check($sformatf("%s_nframes", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    check($sformatf("%s_segpulses", tag), seg_pulses, m_seg);
    check($sformatf("%s_errcnt", tag), err_cnt, m_err);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          fv;
    int          rs;
    logic [1:0]  rcc;
    logic [6:0]  ran;
    bit          rdp;

    rst_n = 1'b0; cc_in = '0; an_in = '0; dp_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_d_out", d_out, 8'h00);
    check("rst_dp_out", dp_out, 2'b00);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_changed", changed, 1'b0);
    check("rst_seg_err", seg_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_stale", stale, 1'b0);
    rst_n = 1'b1;

    // Scan 0x3A with dp = 10; frame one cycle after the lo accept.
    dw(2'b01, 7'h4F, 1, 8);
    drive(2'b10, 7'h77, 0, 8, fv);
    check("lat_3a", fv, 2 + SETTLE + 1);
    dw(2'b00, 7'h00, 0, 6);
    check("d_3a", d_out, 8'h3A);
    check("dp_3a", dp_out, 2'b10);
    check("one_frame_3a", got_q.size(), 1);
    check("chg_3a", (got_q.size() > 0) ? got_q[0][10] : 1'bx, 1'b1);
    compare_frames("scan_3a");

    // Identical rescan, then 3B.
    dw(2'b01, 7'h4F, 1, 8);
    dw(2'b10, 7'h77, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("chg_rpt", (got_q.size() > 0) ? got_q[0][10] : 1'bx, 1'b0);
    check("d_rpt", d_out, 8'h3A);
    compare_frames("scan_rpt");
    dw(2'b01, 7'h4F, 1, 8);
    dw(2'b10, 7'h7C, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("d_3b", d_out, 8'h3B);
    check("chg_3b", (got_q.size() > 0) ? got_q[0][10] : 1'bx, 1'b1);
    compare_frames("scan_3b");

    // Two-cycle glitch of "1" inside the hi dwell is ignored.
    dw(2'b01, 7'h4F, 1, 2);
    dw(2'b01, 7'h06, 1, 2);
    dw(2'b01, 7'h4F, 1, 8);
    dw(2'b10, 7'h77, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("d_glitch", d_out, 8'h3A);
    compare_frames("glitch");

    // Illegal hi pattern: one seg_err pulse, no frame after a legal lo.
    dw(2'b01, 7'h01, 0, 8);
    dw(2'b00, 7'h00, 0, 2);
    check("err_cnt_illegal", err_cnt, 8'd1);
    dw(2'b10, 7'h77, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("nofr_illegal", got_q.size(), 0);
    compare_frames("illegal");

    // Random dwells: mixed selects, legal/illegal codes, lengths straddling SETTLE.
    for (int i = 0; i < 60; i++) begin
      rs  = $urandom_range(0, 3);
      rcc = (rs <= 1) ? 2'b01 : (rs == 2) ? 2'b10 : ($urandom_range(0, 1) ? 2'b00 : 2'b11);
      ran = ($urandom_range(0, 5) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      rdp = 1'($urandom_range(0, 1));
      dw(rcc, ran, rdp, $urandom_range(1, 8));
    end
    dw(2'b00, 7'h00, 0, 6);
    check("stale_random", stale, 1'b0);
    compare_frames("random");

    // Saturate the illegal-pattern counter.
    for (int i = 0; i < 130; i++) begin
      dw(2'b01, 7'h01, 0, 5);
      dw(2'b01, 7'h02, 0, 5);
    end
    dw(2'b00, 7'h00, 0, 6);
    check("err_cnt_sat", err_cnt, 8'hFF);
    compare_frames("saturate");

    // Timeout: stale rises TIMEOUT cycles after the lo accept, clears only on a frame.
    rst_n = 1'b0; cc_in = '0; an_in = '0; dp_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    stale_rise_cyc = -1;
    dw(2'b01, 7'h4F, 1, 8);
    dw(2'b10, 7'h77, 0, 8);
    dw(2'b00, 7'h00, 0, TIMEOUT + 80);
    check("stale_set", stale, 1'b1);
    check("stale_latency", stale_rise_cyc - last_fv_cyc, TIMEOUT - 1);
    dw(2'b01, 7'h6D, 0, 8);
    check("stale_after_hi", stale, 1'b1);
    dw(2'b10, 7'h07, 1, 8);
    dw(2'b00, 7'h00, 0, 4);
    check("stale_cleared", stale, 1'b0);
    compare_frames("timeout");

    // Reset mid-frame: hi accepted, reset, lo only -> nothing.
    dw(2'b01, 7'h4F, 1, 8);
    rst_n = 1'b0; cc_in = '0; an_in = '0; dp_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dw(2'b10, 7'h77, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("midrst_d_out", d_out, 8'h00);
    check("midrst_dp_out", dp_out, 2'b00);
    check("midrst_nofr", got_q.size(), 0);
    compare_frames("midrst");
    dw(2'b10, 7'h58, 1, 8);
    dw(2'b01, 7'h6D, 0, 8);
    dw(2'b00, 7'h00, 0, 6);
    check("post_rst_d", d_out, 8'h5C);
    check("post_rst_dp", dp_out, 2'b01);
    compare_frames("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
